// File: rtl/fifo_trig_pkg.sv
// Shared types and constants for the FIFO watermark trigger.
package fifo_trig_pkg;

  typedef enum logic [1:0] {
    ST_MID  = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } trig_state_e;

  localparam logic [1:0] ADDR_HI_SET = 2'd0;
  localparam logic [1:0] ADDR_HI_CLR = 2'd1;
  localparam logic [1:0] ADDR_LO_SET = 2'd2;
  localparam logic [1:0] ADDR_LO_CLR = 2'd3;

  localparam int DEB_W = 4;

endpackage

// File: rtl/fifo_trig_chan.sv
// One watched FIFO: hysteresis FSM, debounce counter, rise pulses and sticky irq bits.
//   state   | meaning
//   ST_MID  | count between watermarks, no flag
//   ST_HIGH | full flag asserted until count drops to HI_CLR
//   ST_LOW  | empty flag asserted until count rises to LO_CLR
module fifo_trig_chan
  import fifo_trig_pkg::*;
#(
  parameter int CNT_W   = 21,
  parameter int DEB     = 1,
  parameter int QUALIFY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] hi_set_i,
  input  logic [CNT_W-1:0] hi_clr_i,
  input  logic [CNT_W-1:0] lo_set_i,
  input  logic [CNT_W-1:0] lo_clr_i,
  input  logic             hold_i,
  input  logic             irq_clr_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             full_rise_o,
  output logic             empty_rise_o,
  output logic [1:0]       sticky_o
);

  trig_state_e state_q, state_d, tgt;
  logic [DEB_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic full_rise_q, full_rise_d, empty_rise_q, empty_rise_d;
  logic [1:0] sticky_q, sticky_d;
  logic q_wr, q_rd, samp, cond;

  assign q_wr = (QUALIFY == 0) || wr_en_i;
  assign q_rd = (QUALIFY == 0) || rd_en_i;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    samp    = 1'b0;
    cond    = 1'b0;
    tgt     = ST_MID;
    case (state_q)
      // HIGH is tested first so a misordered config resolves toward full
      ST_MID: begin
        if (q_wr && (count_i >= hi_set_i)) begin
          samp = 1'b1;
          cond = 1'b1;
          tgt  = ST_HIGH;
        end else if (q_rd && (count_i <= lo_set_i)) begin
          samp = 1'b1;
          cond = 1'b1;
          tgt  = ST_LOW;
        end else begin
          samp = q_wr || q_rd;
        end
      end
      ST_HIGH: begin
        samp = q_rd;
        cond = (count_i <= hi_clr_i);
      end
      ST_LOW: begin
        samp = q_wr;
        cond = (count_i >= lo_clr_i);
      end
      default: state_d = ST_MID;
    endcase

    if (samp) begin
      if (!cond) begin
        cnt_d = '0;
      end else if (cnt_inc == DEB_W'(DEB)) begin
        state_d = tgt;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end

    if (hold_i) begin
      state_d = ST_MID;
      cnt_d   = '0;
    end

    full_rise_d  = (state_d == ST_HIGH) && (state_q != ST_HIGH);
    empty_rise_d = (state_d == ST_LOW) && (state_q != ST_LOW);
    sticky_d     = (sticky_q & {2{~irq_clr_i}}) | {empty_rise_d, full_rise_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_MID;
      cnt_q        <= '0;
      full_rise_q  <= 1'b0;
      empty_rise_q <= 1'b0;
      sticky_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      full_rise_q  <= full_rise_d;
      empty_rise_q <= empty_rise_d;
      sticky_q     <= sticky_d;
    end
  end

  assign full_o       = (state_q == ST_HIGH);
  assign empty_o      = (state_q == ST_LOW);
  assign full_rise_o  = full_rise_q;
  assign empty_rise_o = empty_rise_q;
  assign sticky_o     = sticky_q;

endmodule

// File: rtl/fifo_watermark_trigger.sv
// Multi-channel FIFO watermark trigger: shared programmable thresholds, ordering
// check and interrupt reduction around N_CH per-channel trigger instances.
module fifo_watermark_trigger
  import fifo_trig_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 21,
  parameter int DEF_HI_SET = 12799,
  parameter int DEF_HI_CLR = 11520,
  parameter int DEF_LO_SET = 2560,
  parameter int DEF_LO_CLR = 3840,
  parameter int DEB        = 1,
  parameter int QUALIFY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       fifo_wr_en_i,
  input  logic [N_CH-1:0]       fifo_rd_en_i,
  input  logic [N_CH*CNT_W-1:0] fifo_rd_data_count_i,
  input  logic                  cfg_we_i,
  input  logic [1:0]            cfg_addr_i,
  input  logic [CNT_W-1:0]      cfg_data_i,
  input  logic                  irq_clr_i,
  output logic [N_CH-1:0]       trigger_FIFO_full_o,
  output logic [N_CH-1:0]       trigger_FIFO_empty_o,
  output logic [N_CH-1:0]       full_rise_o,
  output logic [N_CH-1:0]       empty_rise_o,
  output logic                  irq_o,
  output logic                  cfg_err_o
);

  logic [CNT_W-1:0] hi_set_q, hi_clr_q, lo_set_q, lo_clr_q;
  logic [2*N_CH-1:0] sticky_all;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_set_q <= CNT_W'(DEF_HI_SET);
      hi_clr_q <= CNT_W'(DEF_HI_CLR);
      lo_set_q <= CNT_W'(DEF_LO_SET);
      lo_clr_q <= CNT_W'(DEF_LO_CLR);
    end else if (cfg_we_i) begin
      case (cfg_addr_i)
        ADDR_HI_SET: hi_set_q <= cfg_data_i;
        ADDR_HI_CLR: hi_clr_q <= cfg_data_i;
        ADDR_LO_SET: lo_set_q <= cfg_data_i;
        default:     lo_clr_q <= cfg_data_i;
      endcase
    end
  end

  // Valid only for LO_SET < LO_CLR <= HI_CLR < HI_SET
  assign cfg_err_o = !((lo_set_q < lo_clr_q) && (lo_clr_q <= hi_clr_q) && (hi_clr_q < hi_set_q));

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    fifo_trig_chan #(
      .CNT_W  (CNT_W),
      .DEB    (DEB),
      .QUALIFY(QUALIFY)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .wr_en_i     (fifo_wr_en_i[c]),
      .rd_en_i     (fifo_rd_en_i[c]),
      .count_i     (fifo_rd_data_count_i[c*CNT_W +: CNT_W]),
      .hi_set_i    (hi_set_q),
      .hi_clr_i    (hi_clr_q),
      .lo_set_i    (lo_set_q),
      .lo_clr_i    (lo_clr_q),
      .hold_i      (cfg_err_o),
      .irq_clr_i   (irq_clr_i),
      .full_o      (trigger_FIFO_full_o[c]),
      .empty_o     (trigger_FIFO_empty_o[c]),
      .full_rise_o (full_rise_o[c]),
      .empty_rise_o(empty_rise_o[c]),
      .sticky_o    (sticky_all[2*c +: 2])
    );
  end

  assign irq_o = |sticky_all;

endmodule

// File: doc/fifo_watermark_trigger.md
# fifo_watermark_trigger

Multi-channel, parametrised FIFO watermark trigger with hysteresis, run-time programmable thresholds, per-channel debounce and a sticky interrupt. It replaces the single-channel fixed-threshold full/empty trigger. It sits beside the capture FIFOs and watches each FIFO's read-side data count. It drives level and pulse full/empty flags toward the readout control logic.

## Interface
Parameters:
- N_CH, 4, number of monitored FIFOs
- CNT_W, 21, width of each data-count input
- DEF_HI_SET, 12799, reset value of high set threshold
- DEF_HI_CLR, 11520, reset value of high clear threshold
- DEF_LO_SET, 2560, reset value of low set threshold
- DEF_LO_CLR, 3840, reset value of low clear threshold
- DEB, 1, consecutive qualified samples required to change state (1..15)
- QUALIFY, 1, 1 = high transitions sampled only on wr_en / low on rd_en; 0 = sample every cycle

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- fifo_wr_en_i  in  N_CH  per-channel FIFO write enable
- fifo_rd_en_i  in  N_CH  per-channel FIFO read enable
- fifo_rd_data_count_i  in  N_CH*CNT_W  packed counts, channel c at [c*CNT_W +: CNT_W], unsigned
- cfg_we_i  in  1  threshold write strobe
- cfg_addr_i  in  2  0=HI_SET 1=HI_CLR 2=LO_SET 3=LO_CLR
- cfg_data_i  in  CNT_W  threshold value
- irq_clr_i  in  1  clears all sticky interrupt bits
- trigger_FIFO_full_o  out  N_CH  level, channel in HIGH state
- trigger_FIFO_empty_o  out  N_CH  level, channel in LOW state
- full_rise_o  out  N_CH  one-cycle pulse on full assertion
- empty_rise_o  out  N_CH  one-cycle pulse on empty assertion
- irq_o  out  1  OR of all 2*N_CH sticky bits
- cfg_err_o  out  1  threshold ordering violated

## Operation
- Per-channel FSM with states MID, HIGH and LOW. Reset state is MID.
- Set and clear conditions, all comparisons unsigned and CNT_W wide:
  - hi_set: count >= HI_SET
  - hi_clr: count <= HI_CLR
  - lo_set: count <= LO_SET
  - lo_clr: count >= LO_CLR
- Qualifiers when QUALIFY=1:
  - MID->HIGH samples only on wr_en cycles.
  - HIGH->MID and MID->LOW sample only on rd_en cycles.
  - LOW->MID samples only on wr_en cycles.
  - When QUALIFY=0, every cycle is a sample.
- Transitions:
  - MID->HIGH on hi_set.
  - MID->LOW on lo_set.
  - HIGH->MID on hi_clr.
  - LOW->MID on lo_clr.
  - HIGH and LOW never move directly into each other; they always pass through MID for at least one cycle.
  - In MID, if both hi_set and lo_set are true (misconfiguration), HIGH wins.
- Debounce: each channel has a 4-bit counter for the pending transition.
  - A qualified sample with the condition true increments the counter.
  - A qualified sample with the condition false zeroes it.
  - An unqualified cycle holds it.
  - The transition fires when the counter would reach DEB. The counter zeroes on every state change.
- Simultaneous wr_en and rd_en on a channel: both qualifiers are active in that cycle.
- Thresholds register on cfg_we_i and take effect on the cycle after the write. They reset to the DEF_* values.
- cfg_err_o is combinational from the threshold registers. It is 1 unless LO_SET < LO_CLR <= HI_CLR < HI_SET.
  - While cfg_err_o=1, every FSM is forced to MID, its flags drop and its debounce counters zero.
- Sticky bits are one per channel per flag. Each is set by its rise pulse and cleared by irq_clr_i. Set wins over clear in the same cycle.

## Timing
- Reset values: all flags, pulses, sticky bits and irq_o are 0; debounce counters are 0; cfg_err_o is 0 with default thresholds.
- Flags are registered. With DEB=1, a flag changes on the clock edge that samples the qualifying condition, so it is visible the following cycle.
- With DEB=N, the flag changes on the edge of the N-th consecutive qualified true sample.
- full_rise_o / empty_rise_o are high for exactly the first cycle their flag reads 1.
- irq_o is registered and rises in the same cycle as the rise pulse.
- Reset asserted mid-operation returns everything to reset values on the next edge, including the thresholds.

## Structure
- Package fifo_trig_pkg holds:
  - the state enum (MID/HIGH/LOW);
  - the cfg address constants (ADDR_HI_SET..ADDR_LO_CLR);
  - the debounce counter width.
- Sub-module fifo_trig_chan contains one channel's FSM, debounce counter, rise-pulse logic and sticky bits. It takes shared thresholds and the cfg_err_o hold as inputs.
- The top instantiates N_CH copies of fifo_trig_chan in a generate loop. The top also owns the threshold registers, the ordering check and the irq_o reduction.

## Test plan
- Upper bound, defaults, DEB=1:
  - ch0 wr_en=1, count 12798 -> no full.
  - count 12799 -> full_o[0]=1 and full_rise_o[0] pulse next cycle, irq_o=1.
  - rd_en=1, count 11521 -> full stays 1.
  - count 11520 -> full clears.
- Lower bound:
  - ch1 rd_en=1, count 2561 -> no empty.
  - count 2560 -> empty_o[1]=1.
  - wr_en=1, count 3839 -> empty holds.
  - count 3840 -> empty clears.
  - Check ch0/ch2/ch3 are unaffected.
- Qualification:
  - QUALIFY=1, count 12799 with wr_en=0 for 10 cycles -> no full.
  - QUALIFY=0, same stimulus -> full after 1 cycle.
- Debounce, DEB=3:
  - count 12799 qualified for 2 cycles, one qualified sample at 12000, then 3 qualified cycles at 12799 -> full only after the final 3.
  - Unqualified gaps inside the 3 samples do not reset the count.
- Config:
  - Write HI_SET=3000 -> cfg_err_o=1 and all flags forced 0.
  - Write HI_SET=13000 -> cfg_err_o=0 next cycle; new threshold applies (12999 no full, 13000 full).
- Interrupt and reset:
  - irq_clr_i in the same cycle as a new rise -> sticky bit stays set.
  - Clear alone -> irq_o=0.
  - Reset while ch0 is HIGH -> all outputs 0 and thresholds at defaults next cycle.
